// File: rtl/karatsuba_mult_axis.sv
// Unsigned WIDTH x WIDTH multiplier using one Karatsuba split, pipelined over four stages with a tag sideband.
// Latency: 4 cycles from operand acceptance to output_tvalid; one product per cycle when not stalled.
// Backpressure: the whole pipeline freezes while output_tvalid && !output_tready; operands are taken only as an A/B pair.
module karatsuba_mult_axis #(
    parameter int WIDTH = 64,
    parameter int TAG_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     input_a_tdata,
    input  logic                 input_a_tvalid,
    output logic                 input_a_tready,
    input  logic [WIDTH-1:0]     input_b_tdata,
    input  logic                 input_b_tvalid,
    output logic                 input_b_tready,
    input  logic [TAG_W-1:0]     input_tag,
    output logic [2*WIDTH-1:0]   output_tdata,
    output logic [TAG_W-1:0]     output_tag,
    output logic                 output_tvalid,
    input  logic                 output_tready,
    output logic                 busy
);
    localparam int H  = WIDTH / 2;
    localparam int SW = H + 1;        // half-sum width, carries the extra bit
    localparam int PW = 2 * H;        // half-product width
    localparam int EW = 2 * H + 2;    // product of two half-sums
    localparam int MW = 2 * H + 1;    // middle term aH*bL + aL*bH
    localparam int RW = 2 * WIDTH;    // full product width

    // Global advance enable: every stage moves together or not at all
    logic en;
    logic accept;

    // Stage valid bits
    logic s1_vld_q, s2_vld_q, s3_vld_q, s4_vld_q;

    // Stage 1: split operands and form half sums
    logic [H-1:0]     s1_ah_d, s1_al_d, s1_bh_d, s1_bl_d;
    logic [SW-1:0]    s1_sa_d, s1_sb_d;
    logic [H-1:0]     s1_ah_q, s1_al_q, s1_bh_q, s1_bl_q;
    logic [SW-1:0]    s1_sa_q, s1_sb_q;
    logic [TAG_W-1:0] s1_tag_q;

    // Stage 2: three partial products
    logic [PW-1:0]    s2_pa_d, s2_pd_d;
    logic [EW-1:0]    s2_pe_d;
    logic [PW-1:0]    s2_pa_q, s2_pd_q;
    logic [EW-1:0]    s2_pe_q;
    logic [TAG_W-1:0] s2_tag_q;

    // Stage 3: middle term recovered from the cross product
    logic [MW-1:0]    s3_mid_d;
    logic [MW-1:0]    s3_mid_q;
    logic [PW-1:0]    s3_pa_q, s3_pd_q;
    logic [TAG_W-1:0] s3_tag_q;

    // Stage 4: recombined product
    logic [RW-1:0]    s4_res_d;
    logic [RW-1:0]    s4_res_q;
    logic [TAG_W-1:0] s4_tag_q;

    assign en             = !s4_vld_q || output_tready;
    assign accept         = en && input_a_tvalid && input_b_tvalid;
    assign input_a_tready = en && input_b_tvalid;
    assign input_b_tready = en && input_a_tvalid;

    assign s1_ah_d = input_a_tdata[WIDTH-1:H];
    assign s1_al_d = input_a_tdata[H-1:0];
    assign s1_bh_d = input_b_tdata[WIDTH-1:H];
    assign s1_bl_d = input_b_tdata[H-1:0];
    assign s1_sa_d = SW'(s1_ah_d) + SW'(s1_al_d);
    assign s1_sb_d = SW'(s1_bh_d) + SW'(s1_bl_d);

    assign s2_pa_d = PW'(s1_ah_q) * PW'(s1_bh_q);
    assign s2_pd_d = PW'(s1_al_q) * PW'(s1_bl_q);
    assign s2_pe_d = EW'(s1_sa_q) * EW'(s1_sb_q);

    // The difference is aH*bL + aL*bH, never negative and below 2^(2H+1)
    assign s3_mid_d = MW'(s2_pe_q - EW'(s2_pa_q) - EW'(s2_pd_q));

    assign s4_res_d = (RW'(s3_pa_q) << WIDTH) + (RW'(s3_mid_q) << H) + RW'(s3_pd_q);

    // Valid bits: cleared asynchronously so in-flight work is dropped at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
            s3_vld_q <= 1'b0;
            s4_vld_q <= 1'b0;
        end else if (en) begin
            s1_vld_q <= accept;
            s2_vld_q <= s1_vld_q;
            s3_vld_q <= s2_vld_q;
            s4_vld_q <= s3_vld_q;
        end
    end

    // Datapath and tags: no reset needed, qualified by the valid bits above
    always_ff @(posedge clk) begin
        if (en) begin
            s1_ah_q  <= s1_ah_d;
            s1_al_q  <= s1_al_d;
            s1_bh_q  <= s1_bh_d;
            s1_bl_q  <= s1_bl_d;
            s1_sa_q  <= s1_sa_d;
            s1_sb_q  <= s1_sb_d;
            s1_tag_q <= input_tag;

            s2_pa_q  <= s2_pa_d;
            s2_pd_q  <= s2_pd_d;
            s2_pe_q  <= s2_pe_d;
            s2_tag_q <= s1_tag_q;

            s3_mid_q <= s3_mid_d;
            s3_pa_q  <= s2_pa_q;
            s3_pd_q  <= s2_pd_q;
            s3_tag_q <= s2_tag_q;

            s4_res_q <= s4_res_d;
            s4_tag_q <= s3_tag_q;
        end
    end

    assign output_tdata  = s4_res_q;
    assign output_tag    = s4_tag_q;
    assign output_tvalid = s4_vld_q;
    assign busy          = s1_vld_q || s2_vld_q || s3_vld_q || s4_vld_q;

endmodule

// File: tb/tb_karatsuba_mult_axis.sv
module tb_karatsuba_mult_axis;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [63:0] a, b;
    logic [7:0]  tag;
    logic        a_vld, b_vld, out_rdy;

    logic         a_rdy64, b_rdy64, ovld64, busy64;
    logic [127:0] odat64;
    logic [7:0]   otag64;
    logic         a_rdy16, b_rdy16, ovld16, busy16;
    logic [31:0]  odat16;
    logic [3:0]   otag16;

    int tests = 0;
    int fails = 0;

    // Reference: products enter a 4-deep delay line that only moves when the output is free or taken
    logic         m_vld   [4];
    logic [127:0] m64_dat [4];
    logic [7:0]   m64_tag [4];
    logic [31:0]  m16_dat [4];
    logic [3:0]   m16_tag [4];
    int n_del = 0;      // deliveries expected by the reference
    int n_obs_del = 0;  // deliveries seen on the DUT
    int n_obs_acc = 0;  // acceptances seen on the DUT

    karatsuba_mult_axis #(.WIDTH(64), .TAG_W(8)) u_dut64 (
        .clk(clk), .rst(rst),
        .input_a_tdata(a), .input_a_tvalid(a_vld), .input_a_tready(a_rdy64),
        .input_b_tdata(b), .input_b_tvalid(b_vld), .input_b_tready(b_rdy64),
        .input_tag(tag),
        .output_tdata(odat64), .output_tag(otag64), .output_tvalid(ovld64),
        .output_tready(out_rdy), .busy(busy64)
    );

    karatsuba_mult_axis #(.WIDTH(16), .TAG_W(4)) u_dut16 (
        .clk(clk), .rst(rst),
        .input_a_tdata(a[15:0]), .input_a_tvalid(a_vld), .input_a_tready(a_rdy16),
        .input_b_tdata(b[15:0]), .input_b_tvalid(b_vld), .input_b_tready(b_rdy16),
        .input_tag(tag[3:0]),
        .output_tdata(odat16), .output_tag(otag16), .output_tvalid(ovld16),
        .output_tready(out_rdy), .busy(busy16)
    );

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h required %0h", name, obs, exp);
        end
    endtask

    task automatic new_ops();
        int r;
        r = int'($urandom_range(0, 7));
        a = (r == 0) ? 64'd0 : (r == 1) ? '1 : {$urandom, $urandom};
        r = int'($urandom_range(0, 7));
        b = (r == 0) ? 64'd0 : (r == 1) ? '1 : {$urandom, $urandom};
        tag = 8'($urandom);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_vld[i] = 1'b0;
    endtask

    // One clock cycle: check DUT outputs at the falling edge against the reference, then advance both
    task automatic step();
        logic en_m, acc, any_vld;
        @(negedge clk);
        en_m    = !m_vld[3] || out_rdy;
        acc     = en_m && a_vld && b_vld;
        any_vld = m_vld[0] || m_vld[1] || m_vld[2] || m_vld[3];
        chk("ovld64",  128'(ovld64),  128'(m_vld[3]));
        chk("ovld16",  128'(ovld16),  128'(m_vld[3]));
        chk("busy64",  128'(busy64),  128'(any_vld));
        chk("busy16",  128'(busy16),  128'(any_vld));
        chk("a_rdy64", 128'(a_rdy64), 128'(en_m && b_vld));
        chk("b_rdy64", 128'(b_rdy64), 128'(en_m && a_vld));
        chk("a_rdy16", 128'(a_rdy16), 128'(en_m && b_vld));
        chk("b_rdy16", 128'(b_rdy16), 128'(en_m && a_vld));
        if (m_vld[3]) begin
            chk("odat64", odat64, m64_dat[3]);
            chk("otag64", 128'(otag64), 128'(m64_tag[3]));
            chk("odat16", 128'(odat16), 128'(m16_dat[3]));
            chk("otag16", 128'(otag16), 128'(m16_tag[3]));
        end
        if (m_vld[3] && out_rdy) n_del++;
        if (ovld64 && out_rdy) n_obs_del++;
        if (a_vld && b_vld && a_rdy64 && b_rdy64) n_obs_acc++;
        if (en_m) begin
            for (int i = 3; i > 0; i--) begin
                m_vld[i]   = m_vld[i-1];
                m64_dat[i] = m64_dat[i-1];
                m64_tag[i] = m64_tag[i-1];
                m16_dat[i] = m16_dat[i-1];
                m16_tag[i] = m16_tag[i-1];
            end
            m_vld[0]   = acc;
            m64_dat[0] = 128'(a) * 128'(b);
            m64_tag[0] = tag;
            m16_dat[0] = 32'(a[15:0]) * 32'(b[15:0]);
            m16_tag[0] = tag[3:0];
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [127:0] held;
        int a0, d0;

        // Reset state
        model_clear();
        rst = 1'b0; a_vld = 1'b0; b_vld = 1'b0; out_rdy = 1'b1;
        a = '0; b = '0; tag = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ovld64", 128'(ovld64), 128'(0));
        chk("rst_busy64", 128'(busy64), 128'(0));
        chk("rst_ovld16", 128'(ovld16), 128'(0));
        chk("rst_busy16", 128'(busy16), 128'(0));
        rst = 1'b1;

        // All-ones operands, 4-cycle latency
        a = '1; b = '1; tag = 8'h5A; a_vld = 1'b1; b_vld = 1'b1;
        step();
        a_vld = 1'b0; b_vld = 1'b0;
        repeat (3) step();
        chk("max_vld",   128'(ovld64), 128'(1));
        chk("max_dat64", odat64, 128'hFFFFFFFFFFFFFFFE0000000000000001);
        chk("max_tag64", 128'(otag64), 128'(8'h5A));
        chk("max_dat16", 128'(odat16), 128'(32'hFFFE0001));
        chk("max_tag16", 128'(otag16), 128'(4'hA));
        step();

        // Back-to-back pair
        a = 64'h0000000100000000; b = 64'd3; tag = 8'h11; a_vld = 1'b1; b_vld = 1'b1;
        step();
        a = 64'd0; b = 64'h1234; tag = 8'h22;
        step();
        a_vld = 1'b0; b_vld = 1'b0;
        repeat (2) step();
        chk("b2b_first", odat64, 128'h300000000);
        step();
        chk("b2b_vld2",   128'(ovld64), 128'(1));
        chk("b2b_second", odat64, 128'd0);
        repeat (4) step();

        // Stream of 8 with a 3-cycle downstream stall
        a0 = n_obs_acc; d0 = n_obs_del;
        held = '0;
        new_ops(); a_vld = 1'b1; b_vld = 1'b1;
        for (int c = 0; c < 40 && (n_obs_acc - a0) < 8; c++) begin
            if (c == 6) held = odat64;
            if (c == 6 || c == 7) begin
                chk("stall_a_rdy", 128'(a_rdy64), 128'(0));
                chk("stall_vld",   128'(ovld64),  128'(1));
            end
            if (c == 7 || c == 8) chk("stall_hold", odat64, held);
            out_rdy = !(c >= 5 && c < 8);
            begin
                int p;
                p = n_obs_acc;
                step();
                if (n_obs_acc != p) new_ops();
            end
        end
        a_vld = 1'b0; b_vld = 1'b0; out_rdy = 1'b1;
        repeat (8) step();
        chk("stream_acc", 128'(n_obs_acc - a0), 128'(8));
        chk("stream_del", 128'(n_obs_del - d0), 128'(8));

        // A valid without B: nothing consumed until B arrives
        a0 = n_obs_acc; d0 = n_obs_del;
        new_ops(); a_vld = 1'b1; b_vld = 1'b0;
        repeat (5) step();
        chk("single_a_rdy", 128'(a_rdy64), 128'(0));
        chk("single_noacc", 128'(n_obs_acc - a0), 128'(0));
        b_vld = 1'b1;
        step();
        a_vld = 1'b0; b_vld = 1'b0;
        repeat (6) step();
        chk("single_acc", 128'(n_obs_acc - a0), 128'(1));
        chk("single_del", 128'(n_obs_del - d0), 128'(1));

        // Asynchronous reset with work in flight
        a_vld = 1'b1; b_vld = 1'b1;
        repeat (3) begin
            new_ops();
            step();
        end
        a_vld = 1'b0; b_vld = 1'b0;
        chk("pre_rst_busy", 128'(busy64), 128'(1));
        #1 rst = 1'b0;
        #1;
        chk("arst_ovld64", 128'(ovld64), 128'(0));
        chk("arst_busy64", 128'(busy64), 128'(0));
        chk("arst_busy16", 128'(busy16), 128'(0));
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        d0 = n_obs_del;
        repeat (8) step();
        chk("post_rst_del", 128'(n_obs_del - d0), 128'(0));

        // Random traffic with random backpressure
        for (int i = 0; i < 10000; i++) begin
            new_ops();
            a_vld   = ($urandom_range(0, 3) != 0);
            b_vld   = ($urandom_range(0, 3) != 0);
            out_rdy = ($urandom_range(0, 2) != 0);
            step();
        end
        a_vld = 1'b0; b_vld = 1'b0; out_rdy = 1'b1;
        repeat (8) step();
        chk("total_del", 128'(n_obs_del), 128'(n_del));
        chk("drained_busy", 128'(busy64), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
